irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Parametrised vectored interrupt controller; replaces the CU's single hwint line with NUM_IRQ prioritised sources. Latches edge- or level-type requests, masks them, arbitrates by fixed priority and presents one request plus vector address to the CU. Tracks in-service channels so only strictly higher-priority sources can preempt. Software configures it through a small word-addressed register port.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..32); channel 0 is highest priority
VECTOR_BASE, 32'h00000010, vector address of channel 0
VECTOR_STRIDE, 1, word distance between consecutive channel vectors

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
irq_in  in  NUM_IRQ  raw source lines, already synchronous to clk
irq_req  out  1  request to CU (drives hwint)
irq_vector  out  32  vector address of the presented channel
irq_id  out  5  index of the presented channel
irq_ack  in  1  one-cycle pulse from CU when it takes the interrupt
eoi  in  1  one-cycle end-of-interrupt pulse
cfg_wr  in  1  register write strobe
cfg_addr  in  2  register select
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data, combinational from cfg_addr

Behaviour:
- One clock; reset synchronous, active-low: when rst==0 at a clk edge, all state clears. Resulting values: ENABLE=0, MODE=0, PENDING=0, INSERVICE=0, prev_in=0, state=IDLE, irq_req=0, irq_vector=0, irq_id=0. cfg_rdata then reads 0 at all addresses. Reset mid-request drops irq_req the following cycle; any ack is ignored while in reset.
- Registers (bits >= NUM_IRQ read 0, ignore writes):
  - addr 0 ENABLE (RW): per-channel enable.
  - addr 1 MODE (RW): 1=rising-edge, 0=level.
  - addr 2 PENDING: read returns pending; write-1-to-clear for edge channels only.
  - addr 3 INSERVICE (RO).
- Edge channels: prev_in registered each cycle. irq_in & ~prev_in sets PENDING the next edge, regardless of ENABLE.
  - Same-cycle set and clear (ack or W1C) on one bit: set wins.
- Level channels: PENDING[i] = irq_in[i] each cycle; W1C and ack have no effect on it.
- Candidate set: PENDING & ENABLE.
  - winner = lowest-index candidate.
  - ceiling = lowest-index INSERVICE bit, or NUM_IRQ if none.
  - eligible iff winner index < ceiling.
- FSM:
  - IDLE: if eligible, latch irq_id=winner and irq_vector=VECTOR_BASE+winner*VECTOR_STRIDE; go to REQ. irq_req=1 from the cycle after the candidate is visible.
  - REQ: irq_req=1; irq_id/irq_vector frozen, even if a higher-priority source arrives or the latched channel is disabled. On irq_ack:
    - INSERVICE[irq_id] set.
    - PENDING[irq_id] cleared if edge-mode.
    - return to IDLE with irq_req=0 in the next cycle.
    - minimum one idle cycle between consecutive requests.
  - irq_ack in IDLE is ignored.
- eoi clears the lowest-index INSERVICE bit; eoi with INSERVICE=0 is a no-op.
- Same-cycle eoi and irq_ack: eoi clears using the pre-ack INSERVICE value, then the ack bit is set.
- Address arithmetic is 32-bit, wrapping modulo 2^32.
- irq_vector and irq_id hold their last value after ack until the next REQ entry.

Test Plan:
- Reset with rst=0, then release; pulse irq_in[3] with ENABLE=0 -> PENDING=0x08, irq_req stays 0. Then write ENABLE=0x08 -> irq_req=1 next cycle, irq_id=3, irq_vector=0x13.
- Edge ch5 and ch2 rise on the same cycle, all enabled, MODE=0xFF -> present ch2 (vector 0x12). After ack, INSERVICE=0x04 and ch5 stays pending, not requested. Pulse eoi -> ch5 requested, vector 0x15.
- Nesting: ch4 in service, ch1 edge fires -> preempting request id=1; INSERVICE=0x12 after ack. First eoi clears bit1, second clears bit4.
- Level ch0 held high, MODE=0 -> request, ack sets INSERVICE=0x01, no re-request. Drop irq_in[0], eoi -> PENDING=0, irq_req stays 0.
- In REQ for ch6, ch0 fires -> irq_id stays 6 until ack; ch0 presented after one idle cycle. W1C 0x40 on the same cycle as a new ch6 edge -> PENDING bit6 remains 1.
- Assert rst=0 for one cycle during REQ -> irq_req=0 and all registers 0 the next cycle; an ack pulse on the following cycle causes no INSERVICE change.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - CU interrupt handshake and config register port for irq_ctrl
interface irq_ctrl_if;
   logic        irq_req;
   logic [31:0] irq_vector;
   logic [4:0]  irq_id;
   logic        irq_ack;
   logic        eoi;
   logic        cfg_wr;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;

   modport slave (
      output irq_req, irq_vector, irq_id, cfg_rdata,
      input  irq_ack, eoi, cfg_wr, cfg_addr, cfg_wdata
   );

   modport master (
      input  irq_req, irq_vector, irq_id, cfg_rdata,
      output irq_ack, eoi, cfg_wr, cfg_addr, cfg_wdata
   );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - vectored fixed-priority interrupt controller with in-service nesting
module irq_ctrl #(
   parameter int unsigned NUM_IRQ       = 8,
   parameter logic [31:0] VECTOR_BASE   = 32'h0000_0010,
   parameter logic [31:0] VECTOR_STRIDE = 32'd1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   irq_ctrl_if.slave          bus
);
   localparam logic [31:0] VALID_MASK =
      (NUM_IRQ >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_IRQ) - 32'd1);

   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_next;

   // Channel state is kept 32 bits wide; bits at and above NUM_IRQ stay zero.
   logic [31:0] enable_q, mode_q, pending_q, inservice_q, prev_q;
   logic [31:0] irq_in_w, candidates, ack_mask, w1c_mask, edge_set, edge_clr;
   logic [31:0] pending_next, inservice_next, eoi_mask, vector_calc, vector_q;
   logic [4:0]  winner, id_q;
   logic [5:0]  ceiling;
   logic        cand_any, eligible, ack_fire, load;

   assign irq_in_w   = 32'(irq_in);
   assign candidates = pending_q & enable_q;

   always_comb begin
      winner   = 5'd0;
      cand_any = 1'b0;
      ceiling  = 6'(NUM_IRQ);
      for (int i = 31; i >= 0; i--) begin
         if (candidates[i]) begin
            winner   = 5'(i);
            cand_any = 1'b1;
         end
         if (inservice_q[i]) ceiling = 6'(i);
      end
   end

   assign eligible    = cand_any && ({1'b0, winner} < ceiling);
   assign vector_calc = VECTOR_BASE + 32'(winner) * VECTOR_STRIDE;
   assign ack_fire    = (state == REQ) && bus.irq_ack;
   assign ack_mask    = ack_fire ? (32'd1 << id_q) : 32'd0;
   assign w1c_mask    = (bus.cfg_wr && bus.cfg_addr == 2'd2) ? bus.cfg_wdata : 32'd0;

   // A new edge outranks a simultaneous W1C or ack clear on the same bit.
   assign edge_set     = irq_in_w & ~prev_q & mode_q;
   assign edge_clr     = (w1c_mask | ack_mask) & mode_q;
   assign pending_next = ((((pending_q & ~edge_clr) | edge_set) & mode_q)
                         | (irq_in_w & ~mode_q)) & VALID_MASK;

   // eoi retires the lowest set bit of the pre-ack in-service set.
   assign eoi_mask       = bus.eoi ? (inservice_q & (~inservice_q + 32'd1)) : 32'd0;
   assign inservice_next = ((inservice_q & ~eoi_mask) | ack_mask) & VALID_MASK;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (eligible) begin
               state_next = REQ;
               load       = 1'b1;
            end
         end
         REQ: begin
            if (bus.irq_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         enable_q    <= 32'd0;
         mode_q      <= 32'd0;
         pending_q   <= 32'd0;
         inservice_q <= 32'd0;
         prev_q      <= 32'd0;
         id_q        <= 5'd0;
         vector_q    <= 32'd0;
      end else begin
         prev_q      <= irq_in_w;
         pending_q   <= pending_next;
         inservice_q <= inservice_next;
         if (load) begin
            id_q     <= winner;
            vector_q <= vector_calc;
         end
         if (bus.cfg_wr && bus.cfg_addr == 2'd0) enable_q <= bus.cfg_wdata & VALID_MASK;
         if (bus.cfg_wr && bus.cfg_addr == 2'd1) mode_q   <= bus.cfg_wdata & VALID_MASK;
      end
   end

   assign bus.irq_req    = (state == REQ);
   assign bus.irq_id     = id_q;
   assign bus.irq_vector = vector_q;

   always_comb begin
      bus.cfg_rdata = 32'd0;
      case (bus.cfg_addr)
         2'd0:    bus.cfg_rdata = enable_q;
         2'd1:    bus.cfg_rdata = mode_q;
         2'd2:    bus.cfg_rdata = pending_q;
         default: bus.cfg_rdata = inservice_q;
      endcase
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - randomized and directed bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;
   localparam int          N      = 8;
   localparam logic [31:0] BASE   = 32'h0000_0010;
   localparam logic [31:0] STRIDE = 32'd1;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq_in;
   logic [31:0]  v;

   irq_ctrl_if bus();

   irq_ctrl #(.NUM_IRQ(N), .VECTOR_BASE(BASE), .VECTOR_STRIDE(STRIDE)) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   bit [N-1:0]  m_en, m_mode, m_pend, m_isr, m_prev;
   bit          m_req;
   int          m_id;
   logic [31:0] m_vec;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input bit [N-1:0] x);
      for (int i = 0; i < N; i++)
         if (x[i]) return i;
      return N;
   endfunction

   // Reference: one clock edge worth of the controller's rules, from pre-edge values.
   task automatic model_step();
      bit [N-1:0] pend_n, isr_n;
      bit         ack, cleared;
      int         w, c;
      if (!rst) begin
         m_en = '0; m_mode = '0; m_pend = '0; m_isr = '0; m_prev = '0;
         m_req = 1'b0; m_id = 0; m_vec = 32'd0;
         return;
      end
      ack = m_req && bus.irq_ack;
      for (int i = 0; i < N; i++) begin
         cleared = (bus.cfg_wr && bus.cfg_addr == 2'd2 && bus.cfg_wdata[i]) || (ack && m_id == i);
         if (!m_mode[i])                     pend_n[i] = irq_in[i];
         else if (irq_in[i] && !m_prev[i])   pend_n[i] = 1'b1;
         else if (cleared)                   pend_n[i] = 1'b0;
         else                                pend_n[i] = m_pend[i];
      end
      isr_n = m_isr;
      if (bus.eoi && m_isr != '0) isr_n[lowest(m_isr)] = 1'b0;
      if (ack) isr_n[m_id] = 1'b1;
      if (m_req) begin
         if (ack) m_req = 1'b0;
      end else begin
         w = lowest(m_pend & m_en);
         c = lowest(m_isr);
         if (w < c) begin
            m_req = 1'b1;
            m_id  = w;
            m_vec = BASE + 32'(w) * STRIDE;
         end
      end
      if (bus.cfg_wr && bus.cfg_addr == 2'd0) m_en   = bus.cfg_wdata[N-1:0];
      if (bus.cfg_wr && bus.cfg_addr == 2'd1) m_mode = bus.cfg_wdata[N-1:0];
      m_pend = pend_n;
      m_isr  = isr_n;
      m_prev = irq_in;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.cfg_addr = a;
      #1;
      d = bus.cfg_rdata;
   endtask

   task automatic tick();
      logic [31:0] d;
      model_step();
      @(posedge clk);
      #1;
      bus.cfg_wr  = 1'b0;
      bus.irq_ack = 1'b0;
      bus.eoi     = 1'b0;
      check("irq_req", 32'(bus.irq_req), 32'(m_req));
      check("irq_id", 32'(bus.irq_id), 32'(m_id));
      check("irq_vector", bus.irq_vector, m_vec);
      rd(2'd0, d); check("rd_enable", d, 32'(m_en));
      rd(2'd1, d); check("rd_mode", d, 32'(m_mode));
      rd(2'd2, d); check("rd_pending", d, 32'(m_pend));
      rd(2'd3, d); check("rd_inservice", d, 32'(m_isr));
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
      tick();
   endtask

   task automatic pulse(input logic [N-1:0] m);
      irq_in = m; tick();
      irq_in = '0; tick();
   endtask

   task automatic do_ack();
      bus.irq_ack = 1'b1; tick();
   endtask

   task automatic do_eoi();
      bus.eoi = 1'b1; tick();
   endtask

   initial begin
      rst = 1'b0; irq_in = '0;
      bus.irq_ack = 1'b0; bus.eoi = 1'b0; bus.cfg_wr = 1'b0;
      bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'd0;
      tick(); tick();
      rst = 1'b1;
      tick();
      check("reset_req", 32'(bus.irq_req), 32'd0);

      // Edge latched while disabled, presented once enabled
      wr(2'd1, 32'hFF);
      pulse(8'h08);
      rd(2'd2, v); check("tp1_pending", v, 32'h08);
      check("tp1_noreq", 32'(bus.irq_req), 32'd0);
      wr(2'd0, 32'h08);
      check("tp1_req_wait", 32'(bus.irq_req), 32'd0);
      tick();
      check("tp1_req", 32'(bus.irq_req), 32'd1);
      check("tp1_id", 32'(bus.irq_id), 32'd3);
      check("tp1_vec", bus.irq_vector, 32'h13);
      do_ack(); do_eoi();

      // Simultaneous edges: priority then release by eoi
      wr(2'd0, 32'hFF);
      pulse(8'h24);
      check("tp2_id", 32'(bus.irq_id), 32'd2);
      check("tp2_vec", bus.irq_vector, 32'h12);
      do_ack();
      rd(2'd3, v); check("tp2_isr", v, 32'h04);
      tick(); tick();
      check("tp2_blocked", 32'(bus.irq_req), 32'd0);
      rd(2'd2, v); check("tp2_pend5", v, 32'h20);
      do_eoi(); tick();
      check("tp2_req5", 32'(bus.irq_req), 32'd1);
      check("tp2_vec5", bus.irq_vector, 32'h15);
      do_ack(); do_eoi();

      // Nesting
      pulse(8'h10);
      check("tp3_id4", 32'(bus.irq_id), 32'd4);
      do_ack();
      pulse(8'h02);
      check("tp3_preempt", 32'(bus.irq_id), 32'd1);
      do_ack();
      rd(2'd3, v); check("tp3_isr12", v, 32'h12);
      do_eoi(); rd(2'd3, v); check("tp3_isr10", v, 32'h10);
      do_eoi(); rd(2'd3, v); check("tp3_isr0", v, 32'h00);

      // Level channel
      wr(2'd1, 32'h00);
      irq_in = 8'h01; tick(); tick();
      check("tp4_req", 32'(bus.irq_req), 32'd1);
      check("tp4_id", 32'(bus.irq_id), 32'd0);
      do_ack();
      rd(2'd3, v); check("tp4_isr", v, 32'h01);
      tick(); tick();
      check("tp4_noreq", 32'(bus.irq_req), 32'd0);
      irq_in = '0; bus.eoi = 1'b1; tick(); tick();
      rd(2'd2, v); check("tp4_pend", v, 32'h00);
      check("tp4_idle", 32'(bus.irq_req), 32'd0);

      // Frozen id in REQ, idle gap, set beats W1C
      wr(2'd1, 32'hFF);
      pulse(8'h40);
      pulse(8'h01);
      check("tp5_frozen", 32'(bus.irq_id), 32'd6);
      do_ack();
      check("tp5_gap", 32'(bus.irq_req), 32'd0);
      tick();
      check("tp5_req0", 32'(bus.irq_id), 32'd0);
      do_ack(); do_eoi(); do_eoi();
      irq_in = 8'h40; bus.cfg_wr = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_wdata = 32'h40;
      tick();
      irq_in = '0;
      rd(2'd2, v); check("tp5_setwins", v, 32'h40);

      // Reset during REQ, then a stray ack
      tick();
      check("tp6_inreq", 32'(bus.irq_req), 32'd1);
      rst = 1'b0; tick(); rst = 1'b1;
      check("tp6_req", 32'(bus.irq_req), 32'd0);
      rd(2'd0, v); check("tp6_en", v, 32'd0);
      rd(2'd3, v); check("tp6_isr", v, 32'd0);
      do_ack();
      rd(2'd3, v); check("tp6_ack_ignored", v, 32'd0);

      // Randomized traffic
      wr(2'd1, $urandom);
      wr(2'd0, $urandom | 32'h1);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0) irq_in = N'($urandom & $urandom & $urandom);
         bus.irq_ack = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
         bus.eoi     = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) begin
            bus.cfg_wr    = 1'b1;
            bus.cfg_addr  = 2'($urandom_range(0, 3));
            bus.cfg_wdata = $urandom;
         end
         rst = ($urandom_range(0, 499) != 0);
         tick();
         rst = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
